// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit for MIPS mult/multu/div/divu plus mfhi/mflo/mthi/mtlo.
// Define MULDIV_DIV_EN to build the divider; without it div/divu raise a one-cycle `unsupported` pulse.
// state | meaning
// IDLE  | waiting for an op; mthi/mtlo/mfhi/mflo served here
// RUN   | one radix-2 multiply or divide step per cycle, WIDTH steps
// FIX   | sign correction and HI/LO write-back
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       op_func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             unsupported
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               unsup_q, unsup_d;

  logic               accept, is_mul_op, is_div_op, signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;

`ifdef MULDIV_DIV_EN
  logic               is_div_q, is_div_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

  always_comb begin
    accept    = op_valid && !busy_q && !cancel;
    is_mul_op = (op_func == F_MULT) || (op_func == F_MULTU);
    is_div_op = (op_func == F_DIV) || (op_func == F_DIVU);
    signed_op = (op_func == F_MULT) || (op_func == F_DIV);
    a_mag     = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    b_mag     = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, b_q};
    div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unsup_d = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    a_raw_d   = a_raw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_func == F_MTHI) hi_d = rs_data;
          if (op_func == F_MTLO) lo_d = rs_data;
          if (is_mul_op) begin
            state_d = S_RUN;
            cnt_d   = CNT_INIT;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            b_d     = b_mag;
            neg_d   = signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            is_div_d = 1'b0;
`endif
          end
          if (is_div_op) begin
`ifdef MULDIV_DIV_EN
            state_d   = S_RUN;
            cnt_d     = CNT_INIT;
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            b_d       = b_mag;
            neg_d     = signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            is_div_d  = 1'b1;
            neg_rem_d = signed_op && rs_data[WIDTH-1];
            div0_d    = (rt_data == '0);
            a_raw_d   = rs_data;
`else
            unsup_d = 1'b1;
`endif
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
`ifdef MULDIV_DIV_EN
          acc_d = is_div_q ? div_next : mul_next;
`else
          acc_d = mul_next;
`endif
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
          // Divide by zero keeps the raw dividend so signed fix-up cannot disturb it.
          if (is_div_q) begin
            hi_d = div0_q ? a_raw_q : rem_fix;
            lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      unsup_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      unsup_q <= unsup_d;
`ifdef MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      a_raw_q   <= a_raw_d;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    if (op_func == F_MFHI) rd_data = hi_q;
    if (op_func == F_MFLO) rd_data = lo_q;
  end

  assign stall       = op_valid && busy_q;
  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign unsupported = unsup_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer (WIDTH 32); divide cases follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        reset, op_valid, cancel;
  logic [5:0]  op_func;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy, unsupported;
  logic [31:0] rd_data, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int          checks = 0;
  int          errors = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_func(op_func),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .stall(stall), .busy(busy), .rd_data(rd_data), .hi(hi), .lo(lo),
    .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_v, q, r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.hi = model_hi;
    e.lo = model_lo;
    case (f)
      F_MULT:  begin p = sa * sb_v; e.hi = p[63:32]; e.lo = p[31:0]; end
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
`ifdef MULDIV_DIV_EN
      F_DIV, F_DIVU: begin
        if (b == 0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
        end else if (f == F_DIV) begin
          q = sa / sb_v;
          r = sa % sb_v;
          e.hi = r[31:0];
          e.lo = q[31:0];
        end else begin
          e.hi = a % b;
          e.lo = a / b;
        end
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic move_to(input logic [5:0] f, input logic [31:0] v);
    @(negedge clk);
    op_valid = 1'b1; op_func = f; rs_data = v;
    @(negedge clk);
    op_valid = 1'b0;
    if (f == F_MTHI) model_hi = v; else model_lo = v;
    #1;
    chk("mt_hi", hi, model_hi);
    chk("mt_lo", lo, model_lo);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_mflo);
    exp_t e;
    int   cycles;
    sb.push_back(model(f, a, b));
    @(negedge clk);
    op_valid = 1'b1; op_func = f; rs_data = a; rt_data = b;
    #1 chk({tag, "_stall_idle"}, stall, 1'b0);
    @(negedge clk);
    if (hold_mflo) op_func = F_MFLO; else op_valid = 1'b0;
    #1;
    cycles = 0;
    while ((hold_mflo ? stall : busy) && cycles < 100) begin
      @(negedge clk); #1;
      cycles++;
    end
    chk({tag, "_cycles"}, cycles, 33);
    e = sb.pop_front();
    chk({tag, "_hi"}, hi, e.hi);
    chk({tag, "_lo"}, lo, e.lo);
    if (hold_mflo) chk({tag, "_rd_mflo"}, rd_data, e.lo);
    model_hi = e.hi;
    model_lo = e.lo;
    op_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; cancel = 1'b0;
    op_func = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_unsup", unsupported, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rd", rd_data, 32'h0);
    reset = 1'b0;

    // Reset in the middle of a multiply clears everything.
    move_to(F_MTLO, 32'h55);
    @(negedge clk);
    op_valid = 1'b1; op_func = F_MULT; rs_data = 7; rt_data = 9;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    op_valid = 1'b1; op_func = F_MFLO;
    #1 chk("midrst_mflo", rd_data, 32'h0);
    op_valid = 1'b0;

    move_to(F_MTHI, 32'h1234);
    @(negedge clk);
    op_valid = 1'b1; op_func = F_MFHI;
    #1;
    chk("mfhi_rd", rd_data, 32'h1234);
    chk("mfhi_stall", stall, 1'b0);
    op_func = F_MFLO;
    #1 chk("mflo_rd", rd_data, model_lo);
    op_valid = 1'b0;

    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_const", lo, 32'h0000_0001);
    run_op("mult_neg", F_MULT, -32'sd3, 32'sd5, 1'b0);
    chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFF_FFF1);
    for (int i = 0; i < 4; i++)
      run_op("mult_rand", (i % 2) ? F_MULTU : F_MULT, $urandom, $urandom, 1'b0);

    // Cancel during RUN leaves HI/LO intact.
    move_to(F_MTHI, 32'h1234);
    @(negedge clk);
    op_valid = 1'b1; op_func = F_MULT; rs_data = 11; rt_data = 13;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("cancel_busy", busy, 1'b0);
    chk("cancel_hi", hi, 32'h1234);
    chk("cancel_lo", lo, model_lo);

    // Cancel in IDLE blocks acceptance.
    @(negedge clk);
    op_valid = 1'b1; op_func = F_MTLO; rs_data = 32'hDEAD; cancel = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; cancel = 1'b0;
    #1 chk("cancel_idle_lo", lo, model_lo);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", F_DIV, -32'sd7, 32'sd2, 1'b0);
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", hi, 32'hFFFF_FFFF);
    run_op("divu_zero", F_DIVU, 32'd100, 32'd0, 1'b0);
    chk("divu_zero_hi_const", hi, 32'd100);
    run_op("div_zero_neg", F_DIV, -32'sd5, 32'd0, 1'b0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    chk("div_ovf_hi_const", hi, 32'h0);
    for (int i = 0; i < 4; i++)
      run_op("div_rand", (i % 2) ? F_DIVU : F_DIV, $urandom, $urandom_range(1, 70000), 1'b0);
`else
    begin
      exp_t e;
      sb.push_back(model(F_DIVU, 32'd9, 32'd3));
      @(negedge clk);
      op_valid = 1'b1; op_func = F_DIVU; rs_data = 9; rt_data = 3;
      #1;
      chk("unsup_stall", stall, 1'b0);
      chk("unsup_pre", unsupported, 1'b0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("unsup_pulse", unsupported, 1'b1);
      chk("unsup_busy", busy, 1'b0);
      e = sb.pop_front();
      chk("unsup_hi", hi, e.hi);
      chk("unsup_lo", lo, e.lo);
      @(negedge clk);
      #1 chk("unsup_end", unsupported, 1'b0);
    end
`endif

    run_op("mult_after", F_MULT, 32'd6, -32'sd7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Multi-cycle sequencer for the MIPS `mult`, `multu`, `div` and `divu` instructions, which the current decode path leaves unsupported.
- Owns the HI/LO register pair and serves `mfhi`, `mflo`, `mthi` and `mtlo`.
- Sits beside the ALU in the execute stage. The decoder forwards R-type funct codes 0x10–0x13 and 0x18–0x1B here.
- Stalls the pipeline while an iterative operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand/HI/LO width; must be even, ≥ 8.
- `CNT_W`, 6, iteration counter width; must hold the value `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset. One clock domain; reset is asynchronous and active-high.
- `op_valid`  in  1  execute stage presents a HI/LO-class instruction.
- `op_func`  in  6  instruction[5:0]: 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
- `rs_data`  in  WIDTH  operand A / dividend / mthi-mtlo source.
- `rt_data`  in  WIDTH  operand B / divisor.
- `cancel`  in  1  pipeline flush; aborts an in-flight operation.
- `stall`  out  1  hold the execute stage. Combinational.
- `busy`  out  1  iterative operation in flight. Registered.
- `rd_data`  out  WIDTH  mfhi/mflo read data. Combinational from HI/LO.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `unsupported`  out  1  one-cycle pulse; div accepted while divider compiled out.

## Operation
**Accept rule**
- An op is accepted on a rising edge when `op_valid && !stall`.
- `op_func` values outside the list are ignored.
- `stall = op_valid && busy`. Any listed op presented while busy waits, including mfhi/mflo.

**mthi / mtlo**
- Write `rs_data` to HI / LO on the accept edge.

**mfhi / mflo**
- `rd_data` = HI or LO, combinationally, whenever `op_func` selects it.
- `rd_data` = 0 otherwise.

**State machine**
- IDLE → RUN on accept of 0x18–0x1B.
  - Latch operand magnitudes: absolute value for signed ops, raw for unsigned.
  - Latch the result signs.
  - Counter = `WIDTH`.
- RUN: one radix-2 step per cycle; counter decrements.
  - Multiply: shift-add into a 2×WIDTH accumulator.
  - Divide: restoring shift-subtract.
- RUN → FIX when the counter reaches 1, i.e. after exactly `WIDTH` steps.
- FIX: apply sign correction.
  - Signed mult: negate the 2×WIDTH product when the operand signs differ.
  - Signed div: quotient negated when the signs differ; remainder takes the dividend's sign.
  - Write HI/LO. Go to IDLE.

**Results**
- Mult: HI = product[2W-1:W], LO = product[W-1:0].
- Div: LO = quotient, HI = remainder.

**Boundary cases**
- Divide by zero (signed or unsigned): LO = all ones, HI = `rs_data` as latched. No exception.
- Signed 0x80000000 / −1: LO = 0x80000000, HI = 0. The magnitude path gives this without a special case.
- `cancel` in RUN or FIX: go to IDLE next edge; HI/LO unchanged; `busy` drops.
- `cancel` with `op_valid` in IDLE: the op is not accepted.
- Reset mid-operation: IDLE, HI = LO = 0, all outputs 0.

## Timing
- Reset values:
  - State IDLE; `busy` 0; `hi` 0; `lo` 0; `unsupported` 0.
  - `stall` 0 and `rd_data` 0 while inputs are low.
- mult/div accepted at edge E0:
  - `busy` = 1 after E0.
  - RUN occupies edges E1…E(WIDTH).
  - FIX at edge E(WIDTH+1) updates HI/LO and clears `busy`.
  - Total 33 cycles for `WIDTH` = 32.
- A mfhi held from the cycle after E0 stalls 33 cycles and reads the new value in the cycle HI/LO update is visible.
- Back-to-back: a new mult/div may be accepted in the first cycle `busy` = 0.
- mthi/mtlo: single-cycle, visible on `hi`/`lo` the next cycle.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour above.
- `MULDIV_DIV_EN` undefined: divider datapath removed.
  - div/divu is accepted in one cycle with no stall and no state change.
  - HI/LO unchanged.
  - `unsupported` pulses for the cycle after the accept edge.
  - mult paths are unchanged.

## Test plan
- Reset asserted mid-RUN of mult 7×9 → `busy` 0 and `hi`=`lo`=0 immediately; mflo afterwards returns 0.
- multu 0xFFFFFFFF × 0xFFFFFFFF, mflo held next cycle → `stall` high 33 cycles; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- mult −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. div −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- divu 100 / 0 → `lo`=0xFFFFFFFF, `hi`=100. div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- mthi 0x1234 then mflo/mfhi → `rd_data` 0x1234 on mfhi with no stall. `cancel` at RUN cycle 10 of mult → HI/LO keep 0x1234 / prior LO.
- With `MULDIV_DIV_EN` undefined: divu 9/3 → no stall, `unsupported` one-cycle pulse, HI/LO unchanged.
